// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer - LM/SM micro-op sequencer for the IITB-RISC pipeline.
// Walks an 8-bit register mask and emits one memory micro-op per set bit,
// in ascending register order with contiguous addresses. Upstream stages are
// held while a sequence is running.
// Optional feature: define LMSM_BASE_WB_EN to append a base-register
// write-back micro-op (final address + ADDR_STEP into base_reg) after the
// last transfer.

module lmsm_sequencer #(
  parameter int         ADDR_W     = 16,
  parameter int         ADDR_STEP  = 2,
  parameter logic [1:0] WB_SEL_MEM = 2'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_sm,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        reg_mask,
  input  logic [2:0]        base_reg,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              busy,
  output logic              stall_up,
  output logic              uop_valid,
  output logic [2:0]        uop_rf_addr,
  output logic [ADDR_W-1:0] uop_mem_addr,
  output logic              uop_mem_rd,
  output logic              uop_mem_wr,
  output logic              uop_rf_we,
  output logic [1:0]        uop_wb_sel,
  output logic              done
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

`ifdef LMSM_BASE_WB_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [7:0]          mask_q, mask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                is_sm_q, is_sm_d;

  logic                valid_d;
  logic [2:0]          rf_addr_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                mem_rd_d;
  logic                mem_wr_d;
  logic                rf_we_d;
  logic [1:0]          wb_sel_d;
  logic                done_d;

`ifdef LMSM_BASE_WB_EN
  logic [2:0]          base_reg_q, base_reg_d;
`else
  logic                unused_base_reg;
  assign unused_base_reg = ^base_reg;
`endif

  // Index of the lowest set bit; the caller guarantees the mask is non-zero.
  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_idx = 3'(i);
    end
  endfunction

  // Mask with its lowest set bit removed.
  function automatic logic [7:0] clear_lowest(input logic [7:0] m);
    clear_lowest = m & (m - 8'd1);
  endfunction

  assign busy     = (state_q != IDLE);
  assign stall_up = busy;

  // Next-state and next-output logic; priority is flush > ex_stall > normal.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    is_sm_d    = is_sm_q;
`ifdef LMSM_BASE_WB_EN
    base_reg_d = base_reg_q;
`endif
    valid_d    = 1'b0;
    rf_addr_d  = 3'd0;
    mem_addr_d = '0;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    rf_we_d    = 1'b0;
    wb_sel_d   = 2'd0;
    done_d     = 1'b0;

    if (flush) begin
      state_d = IDLE;
      mask_d  = 8'd0;
      addr_d  = '0;
      is_sm_d = 1'b0;
    end else if (state_q != IDLE && ex_stall) begin
      valid_d    = uop_valid;
      rf_addr_d  = uop_rf_addr;
      mem_addr_d = uop_mem_addr;
      mem_rd_d   = uop_mem_rd;
      mem_wr_d   = uop_mem_wr;
      rf_we_d    = uop_rf_we;
      wb_sel_d   = uop_wb_sel;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            is_sm_d = is_sm;
            addr_d  = base_addr;
            mask_d  = clear_lowest(reg_mask);
`ifdef LMSM_BASE_WB_EN
            base_reg_d = base_reg;
`endif
            if (reg_mask != 8'd0) begin
              state_d    = RUN;
              valid_d    = 1'b1;
              rf_addr_d  = lowest_idx(reg_mask);
              mem_addr_d = base_addr;
              mem_rd_d   = ~is_sm;
              mem_wr_d   = is_sm;
              rf_we_d    = ~is_sm;
              wb_sel_d   = is_sm ? 2'd0 : WB_SEL_MEM;
            end else begin
`ifdef LMSM_BASE_WB_EN
              state_d    = WB;
              valid_d    = 1'b1;
              rf_addr_d  = base_reg;
              mem_addr_d = base_addr;
              rf_we_d    = 1'b1;
`else
              done_d     = 1'b1;
`endif
            end
          end
        end

        RUN: begin
          if (mask_q != 8'd0) begin
            valid_d    = 1'b1;
            rf_addr_d  = lowest_idx(mask_q);
            mem_addr_d = addr_q + STEP;
            addr_d     = addr_q + STEP;
            mask_d     = clear_lowest(mask_q);
            mem_rd_d   = ~is_sm_q;
            mem_wr_d   = is_sm_q;
            rf_we_d    = ~is_sm_q;
            wb_sel_d   = is_sm_q ? 2'd0 : WB_SEL_MEM;
          end else begin
`ifdef LMSM_BASE_WB_EN
            state_d    = WB;
            valid_d    = 1'b1;
            rf_addr_d  = base_reg_q;
            mem_addr_d = addr_q + STEP;
            addr_d     = addr_q + STEP;
            rf_we_d    = 1'b1;
`else
            state_d    = IDLE;
            addr_d     = '0;
            done_d     = 1'b1;
`endif
          end
        end

`ifdef LMSM_BASE_WB_EN
        WB: begin
          state_d = IDLE;
          addr_d  = '0;
          done_d  = 1'b1;
        end
`endif

        default: begin
          state_d = IDLE;
          mask_d  = 8'd0;
          addr_d  = '0;
        end
      endcase
    end
  end

  // State, sequencing registers and registered micro-op outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= 8'd0;
      addr_q       <= '0;
      is_sm_q      <= 1'b0;
`ifdef LMSM_BASE_WB_EN
      base_reg_q   <= 3'd0;
`endif
      uop_valid    <= 1'b0;
      uop_rf_addr  <= 3'd0;
      uop_mem_addr <= '0;
      uop_mem_rd   <= 1'b0;
      uop_mem_wr   <= 1'b0;
      uop_rf_we    <= 1'b0;
      uop_wb_sel   <= 2'd0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      is_sm_q      <= is_sm_d;
`ifdef LMSM_BASE_WB_EN
      base_reg_q   <= base_reg_d;
`endif
      uop_valid    <= valid_d;
      uop_rf_addr  <= rf_addr_d;
      uop_mem_addr <= mem_addr_d;
      uop_mem_rd   <= mem_rd_d;
      uop_mem_wr   <= mem_wr_d;
      uop_rf_we    <= rf_we_d;
      uop_wb_sel   <= wb_sel_d;
      done         <= done_d;
    end
  end

  // A finished sequence never overlaps a live micro-op.
  a_done_excl : assert property (@(posedge clk) disable iff (rst)
    !(done && uop_valid));

  // Outside a sequence the micro-op bus is idle.
  a_idle_quiet : assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> !uop_valid);

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer - scoreboard bench for lmsm_sequencer.
// Expected micro-ops are queued when a sequence is started and compared as
// the DUT presents them; held (stalled) micro-ops are re-checked every cycle.

module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_sm;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic [2:0]  base_reg;
  logic        ex_stall;
  logic        flush;
  logic        busy;
  logic        stall_up;
  logic        uop_valid;
  logic [2:0]  uop_rf_addr;
  logic [15:0] uop_mem_addr;
  logic        uop_mem_rd;
  logic        uop_mem_wr;
  logic        uop_rf_we;
  logic [1:0]  uop_wb_sel;
  logic        done;

  typedef struct {
    logic [2:0]  rf;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic        we;
    logic [1:0]  wb;
  } uop_t;

  uop_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  lmsm_sequencer #(
    .ADDR_W     (16),
    .ADDR_STEP  (2),
    .WB_SEL_MEM (2'd1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_sm        (is_sm),
    .base_addr    (base_addr),
    .reg_mask     (reg_mask),
    .base_reg     (base_reg),
    .ex_stall     (ex_stall),
    .flush        (flush),
    .busy         (busy),
    .stall_up     (stall_up),
    .uop_valid    (uop_valid),
    .uop_rf_addr  (uop_rf_addr),
    .uop_mem_addr (uop_mem_addr),
    .uop_mem_rd   (uop_mem_rd),
    .uop_mem_wr   (uop_mem_wr),
    .uop_rf_we    (uop_rf_we),
    .uop_wb_sel   (uop_wb_sel),
    .done         (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case a wait goes wrong.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({busy, stall_up, uop_valid, uop_rf_addr, uop_mem_addr,
                uop_mem_rd, uop_mem_wr, uop_rf_we, uop_wb_sel, done});
  endfunction

  // Starts one sequence, scoreboards every presented micro-op and checks
  // done timing, busy length and micro-op count. flush_idx >= 0 squashes the
  // sequence when that micro-op (0-based) is presented.
  task automatic applyStimulus(input logic sm, input logic [15:0] base,
                               input logic [7:0] mask, input logic [2:0] breg,
                               input int stall_idx, input int stall_len,
                               input int flush_idx, input bit noise);
    uop_t        u;
    logic [15:0] a;
    int          n_uops, acc, busy_cycles, done_cycle, stalls_left, stalls_used;
    bit          flushed, finished;

    exp_q.delete();
    a      = base;
    n_uops = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        u.rf = 3'(i); u.addr = a; u.rd = ~sm; u.wr = sm; u.we = ~sm;
        u.wb = sm ? 2'd0 : 2'd1;
        exp_q.push_back(u);
        a = a + 16'd2;
        n_uops++;
      end
    end
`ifdef LMSM_BASE_WB_EN
    u.rf = breg; u.addr = a; u.rd = 1'b0; u.wr = 1'b0; u.we = 1'b1; u.wb = 2'd0;
    exp_q.push_back(u);
    n_uops++;
`endif

    start = 1'b1; is_sm = sm; base_addr = base; reg_mask = mask; base_reg = breg;
    acc = 0; busy_cycles = 0; done_cycle = -1;
    stalls_left = stall_len; stalls_used = 0;
    flushed = 1'b0; finished = 1'b0;

    for (int cyc = 1; cyc <= 60 && !finished; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; ex_stall = 1'b0; flush = 1'b0;
      if (flushed) begin
        checkOutput("flush_valid", 32'(uop_valid), 32'd0);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_done", 32'(done), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        checkOutput("flush_no_done", 32'(done), 32'd0);
        checkOutput("flush_no_uop", 32'(uop_valid), 32'd0);
        finished = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        checkOutput("done_uop_excl", 32'(done & uop_valid), 32'd0);
        if (uop_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("extra_uop", 32'd1, 32'd0);
          end else begin
            checkOutput("uop_rf_addr", 32'(uop_rf_addr), 32'(exp_q[0].rf));
            checkOutput("uop_mem_addr", 32'(uop_mem_addr), 32'(exp_q[0].addr));
            checkOutput("uop_ctrl", 32'({uop_mem_rd, uop_mem_wr, uop_rf_we, uop_wb_sel}),
                        32'({exp_q[0].rd, exp_q[0].wr, exp_q[0].we, exp_q[0].wb}));
            if (acc == stall_idx && stalls_left > 0) begin
              ex_stall = 1'b1;
              stalls_left--;
              stalls_used++;
            end else begin
              void'(exp_q.pop_front());
              acc++;
              if (acc - 1 == flush_idx) begin
                flush   = 1'b1;
                flushed = 1'b1;
              end
            end
          end
          if (noise && !flush) begin
            start     = 1'b1;
            is_sm     = 1'($urandom);
            base_addr = 16'($urandom);
            reg_mask  = 8'($urandom);
          end
        end
        if (done) begin
          done_cycle = cyc;
          finished   = 1'b1;
        end
      end
    end

    if (flush_idx >= 0) begin
      checkOutput("flush_seen", 32'(flushed), 32'd1);
    end else begin
      checkOutput("done_cycle", 32'(done_cycle), 32'(n_uops + stalls_used + 1));
      checkOutput("busy_cycles", 32'(busy_cycles), 32'(n_uops + stalls_used));
      checkOutput("uop_count", 32'(acc), 32'(n_uops));
      checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
      if (finished) begin
        @(posedge clk); #1;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("idle_after_done", 32'(uop_valid), 32'd0);
      end
    end
    ex_stall = 1'b0; flush = 1'b0; start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_sm = 1'b0; base_addr = 16'h0; reg_mask = 8'h0;
    base_reg = 3'd0; ex_stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", all_outputs(), 32'd0);
    rst = 1'b0;

    $display("[TB] LM three transfers");
    applyStimulus(1'b0, 16'h0100, 8'b1000_0101, 3'd0, -1, 0, -1, 1'b0);

    $display("[TB] SM with address wrap");
    applyStimulus(1'b1, 16'hFFFE, 8'h03, 3'd1, -1, 0, -1, 1'b0);

    $display("[TB] LM full mask, stall on R3, start noise while busy");
    applyStimulus(1'b0, 16'h1000, 8'hFF, 3'd5, 3, 2, -1, 1'b1);

    $display("[TB] empty mask");
    applyStimulus(1'b0, 16'h2222, 8'h00, 3'd2, -1, 0, -1, 1'b0);

    $display("[TB] flush on second micro-op");
    applyStimulus(1'b0, 16'h3000, 8'h0F, 3'd0, -1, 0, 1, 1'b0);
    applyStimulus(1'b1, 16'h4000, 8'hA0, 3'd6, -1, 0, -1, 1'b0);

    $display("[TB] start dropped when flushed in the same cycle");
    start = 1'b1; flush = 1'b1; base_addr = 16'h1234; reg_mask = 8'h11;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checkOutput("start_flush_dropped", all_outputs(), 32'd0);
    @(posedge clk); #1;
    checkOutput("start_flush_quiet", all_outputs(), 32'd0);

    $display("[TB] reset mid-sequence");
    start = 1'b1; is_sm = 1'b0; base_addr = 16'h5000; reg_mask = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midseq_reset_outputs", all_outputs(), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("post_reset_quiet", 32'({uop_valid, done, busy}), 32'd0);
    end
    applyStimulus(1'b0, 16'h0200, 8'h01, 3'd3, -1, 0, -1, 1'b0);

    $display("[TB] random sequences");
    for (int r = 0; r < 6; r++) begin
      applyStimulus(1'($urandom), 16'($urandom), 8'($urandom), 3'($urandom),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), -1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
